// File: rtl/dmem_unit.sv
// MEM-stage data memory: byte/half/word loads and stores with combinational
// reads, a sticky misaligned-access flag and a registered debug scan port.
module dmem_unit #(
  parameter int DEPTH_WORDS = 128,
  parameter int AW          = 9,
  parameter int SCAN_ST     = 0,
  parameter int SCAN_END    = 16
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          mem_write,
  input  logic [AW-1:0] adder,
  input  logic [31:0]   write_data,
  input  logic [2:0]    lwhb,
  input  logic [2:0]    swhb,
  output logic [31:0]   read_data,
  input  logic          scan_tick,
  input  logic          scan_hold,
  output logic [31:0]   dm_data,
  output logic          misalign_err
);

  localparam int WIW = AW - 2;
  localparam int SIW = (WIW > 7) ? WIW : 7;

  typedef enum logic [1:0] {
    SzWord    = 2'b00,
    SzHalf    = 2'b01,
    SzByte    = 2'b10,
    SzWordAlt = 2'b11
  } accSize_e;

  logic [31:0]    mem [DEPTH_WORDS];
  logic [WIW-1:0] wordIdx;
  logic [1:0]     lane;
  logic [31:0]    curWord;
  logic [15:0]    halfSel;
  logic [7:0]     byteSel;
  logic [3:0]     wrMask;
  logic [31:0]    wrData;
  logic           misalignNow;
  logic [SIW-1:0] scanIdx;
  logic [WIW-1:0] scanWordIdx;
  logic           unusedSwhbExt;

  assign wordIdx       = adder[AW-1:2];
  assign lane          = adder[1:0];
  assign curWord       = mem[wordIdx];
  assign scanWordIdx   = scanIdx[WIW-1:0];
  assign unusedSwhbExt = swhb[2];

  // A word access must sit on lane 0, a half on an even lane; bytes never fault.
  function automatic logic isMisaligned(input logic [1:0] sz, input logic [1:0] ln);
    case (accSize_e'(sz))
      SzHalf:  return ln[0];
      SzByte:  return 1'b0;
      default: return ln != 2'b00;
    endcase
  endfunction

  assign misalignNow = mem_write ? isMisaligned(swhb[1:0], lane)
                                 : isMisaligned(lwhb[1:0], lane);

  // Store lanes: replicate the right-aligned data so each lane finds its byte.
  // NOTE: every signal written here gets a value before the case, so no latch is inferred.
  always_comb begin
    wrMask = 4'b1111;
    wrData = write_data;
    case (accSize_e'(swhb[1:0]))
      SzHalf: begin
        wrMask = adder[1] ? 4'b1100 : 4'b0011;
        wrData = {2{write_data[15:0]}};
      end
      SzByte: begin
        wrMask = 4'b0001 << lane;
        wrData = {4{write_data[7:0]}};
      end
      default: ;
    endcase
  end

  always_comb begin
    halfSel   = adder[1] ? curWord[31:16] : curWord[15:0];
    byteSel   = curWord[{lane, 3'b000} +: 8];
    read_data = curWord;
    case (accSize_e'(lwhb[1:0]))
      SzHalf:  read_data = lwhb[2] ? {16'h0000, halfSel} : {{16{halfSel[15]}}, halfSel};
      SzByte:  read_data = lwhb[2] ? {24'h000000, byteSel} : {{24{byteSel[7]}}, byteSel};
      default: ;
    endcase
  end

  // NOTE: the array lives in flops because every word must clear on reset;
  // an asynchronously cleared array cannot map onto a block RAM.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < DEPTH_WORDS; i++) mem[i] <= '0;
    end else if (mem_write) begin
      for (int b = 0; b < 4; b++)
        if (wrMask[b]) mem[wordIdx][8*b +: 8] <= wrData[8*b +: 8];
    end
  end

  // NOTE: non-blocking updates mean the scan below sees the pre-store word at a shared edge.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      scanIdx <= SIW'(SCAN_ST);
      dm_data <= '0;
    end else if (scan_tick) begin
      dm_data <= {1'b0, scanIdx[6:0], mem[scanWordIdx][23:0]};
      if (!scan_hold)
        scanIdx <= (scanIdx == SIW'(SCAN_END - 1)) ? SIW'(SCAN_ST) : scanIdx + SIW'(1);
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)            misalign_err <= 1'b0;
    else if (misalignNow) misalign_err <= 1'b1;
  end

endmodule

// File: tb/tb_dmem_unit.sv
// Scoreboard bench for dmem_unit: a byte-array reference model feeds an
// expectation queue that a negedge monitor drains against the DUT.
module tb_dmem_unit;

  localparam int DEPTH = 128;
  localparam int AWB   = 9;
  localparam int S_ST  = 0;
  localparam int S_END = 4;

  logic           clk = 1'b0;
  logic           rstn, mem_write, scan_tick, scan_hold;
  logic [AWB-1:0] adder;
  logic [31:0]    write_data;
  logic [2:0]     lwhb, swhb;
  logic [31:0]    read_data, dm_data;
  logic           misalign_err;

  always #5 clk = ~clk;

  dmem_unit #(.DEPTH_WORDS(DEPTH), .AW(AWB), .SCAN_ST(S_ST), .SCAN_END(S_END)) dut (
    .clk(clk), .rstn(rstn), .mem_write(mem_write), .adder(adder),
    .write_data(write_data), .lwhb(lwhb), .swhb(swhb), .read_data(read_data),
    .scan_tick(scan_tick), .scan_hold(scan_hold), .dm_data(dm_data),
    .misalign_err(misalign_err)
  );

  typedef struct {
    logic [31:0] rd;
    logic [31:0] dm;
    logic        err;
    string       tag;
  } exp_t;

  exp_t expQ[$];
  int   checks   = 0;
  int   failures = 0;

  // Reference model: memory as a flat byte array, addresses as plain integers.
  logic [7:0]  mb [DEPTH*4];
  int          scanIdxM;
  logic [31:0] dmM;
  logic        errM;

  function automatic int sizeBytes(input logic [1:0] code);
    case (code)
      2'b01:   return 2;
      2'b10:   return 1;
      default: return 4;
    endcase
  endfunction

  function automatic logic [31:0] wordAt(input int w);
    return {mb[4*w+3], mb[4*w+2], mb[4*w+1], mb[4*w]};
  endfunction

  function automatic logic [31:0] modelLoad(input int addr, input logic [2:0] lt);
    int n = sizeBytes(lt[1:0]);
    int base = addr - (addr % n);
    logic [31:0] v = '0;
    for (int k = 0; k < n; k++) v[8*k +: 8] = mb[base + k];
    if (!lt[2] && n < 4 && v[8*n-1])
      for (int k = n; k < 4; k++) v[8*k +: 8] = 8'hFF;
    return v;
  endfunction

  task automatic modelReset();
    for (int i = 0; i < DEPTH*4; i++) mb[i] = 8'h00;
    scanIdxM = S_ST;
    dmM      = '0;
    errM     = 1'b0;
  endtask

  task automatic modelEdge(input logic we, input int addr, input logic [31:0] wd,
                           input logic [2:0] lw, input logic [2:0] sw,
                           input logic tick, input logic hold);
    logic [31:0] w;
    int n;
    if (tick) begin
      w   = wordAt(scanIdxM);
      dmM = {1'b0, 7'(scanIdxM), w[23:0]};
      if (!hold) scanIdxM = (scanIdxM == S_END - 1) ? S_ST : scanIdxM + 1;
    end
    n = we ? sizeBytes(sw[1:0]) : sizeBytes(lw[1:0]);
    if (we)
      for (int k = 0; k < n; k++) mb[addr - (addr % n) + k] = wd[8*k +: 8];
    if (addr % n != 0) errM = 1'b1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, expv);
    end
  endtask

  // One cycle of stimulus: drive just after the edge, queue what the DUT must show.
  task automatic step(input logic rstnV, input logic we, input int addr,
                      input logic [31:0] wd, input logic [2:0] lw, input logic [2:0] sw,
                      input logic tick, input logic hold, input string tag,
                      input logic useConst = 1'b0, input logic [31:0] constRd = '0);
    exp_t e;
    @(posedge clk);
    #2;
    rstn       = rstnV;
    mem_write  = we;
    adder      = AWB'(addr);
    write_data = wd;
    lwhb       = lw;
    swhb       = sw;
    scan_tick  = tick;
    scan_hold  = hold;
    if (!rstnV) modelReset();
    e.rd  = useConst ? constRd : modelLoad(addr, lw);
    e.dm  = dmM;
    e.err = errM;
    e.tag = tag;
    expQ.push_back(e);
    if (rstnV) modelEdge(we, addr, wd, lw, sw, tick, hold);
  endtask

  task automatic st(input int addr, input logic [31:0] wd, input logic [2:0] sw, input string tag);
    step(1'b1, 1'b1, addr, wd, 3'b000, sw, 1'b0, 1'b0, tag);
  endtask

  task automatic ld(input int addr, input logic [2:0] lw, input string tag,
                    input logic [31:0] constRd);
    step(1'b1, 1'b0, addr, '0, lw, 3'b000, 1'b0, 1'b0, tag, 1'b1, constRd);
  endtask

  task automatic tick(input logic hold, input string tag);
    step(1'b1, 1'b0, 0, '0, 3'b000, 3'b000, 1'b1, hold, tag);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (expQ.size() > 0) begin
        e = expQ.pop_front();
        check({e.tag, " read_data"}, read_data, e.rd);
        check({e.tag, " dm_data"}, dm_data, e.dm);
        check({e.tag, " misalign_err"}, {31'b0, misalign_err}, {31'b0, e.err});
      end
    end
  end

  initial begin : driver
    int wIdx, lane, n, addr;
    logic we;
    logic [2:0] lw, sw;
    rstn = 1'b0; mem_write = 1'b0; adder = '0; write_data = '0;
    lwhb = 3'b000; swhb = 3'b000; scan_tick = 1'b0; scan_hold = 1'b0;
    modelReset();

    step(1'b0, 1'b0, 0, '0, 3'b000, 3'b000, 1'b0, 1'b0, "reset");
    step(1'b0, 1'b0, 0, '0, 3'b000, 3'b000, 1'b0, 1'b0, "reset");
    step(1'b1, 1'b1, 'h040, 32'hCAFEBABE, 3'b000, 3'b000, 1'b0, 1'b0, "first_store");
    ld('h040, 3'b000, "first_store_rd", 32'hCAFEBABE);

    st('h010, 32'h12345678, 3'b000, "st_word");
    ld('h010, 3'b000, "ld_word", 32'h12345678);
    ld('h010, 3'b010, "ld_b0", 32'h00000078);
    ld('h011, 3'b010, "ld_b1", 32'h00000056);
    ld('h012, 3'b010, "ld_b2", 32'h00000034);
    ld('h013, 3'b010, "ld_b3", 32'h00000012);

    st('h011, 32'h000000AB, 3'b010, "st_byte");
    st('h012, 32'h0000F00D, 3'b001, "st_half");
    ld('h010, 3'b000, "merged_word", 32'hF00DAB78);
    ld('h012, 3'b001, "ld_half_s", 32'hFFFFF00D);
    ld('h012, 3'b101, "ld_half_u", 32'h0000F00D);
    ld('h011, 3'b010, "ld_byte_s", 32'hFFFFFFAB);

    step(1'b1, 1'b1, 'h020, 32'hFFFFFFFF, 3'b000, 3'b000, 1'b0, 1'b0, "rdw_same", 1'b1, 32'h0);
    ld('h020, 3'b000, "rdw_next", 32'hFFFFFFFF);

    st('h008, 32'h0ABCDEF1, 3'b000, "scan_seed");
    for (int i = 0; i < 5; i++) tick(1'b0, "scan_run");
    for (int i = 0; i < 2; i++) tick(1'b1, "scan_hold");
    tick(1'b0, "scan_resume");

    st('h006, 32'h5A5A5A5A, 3'b000, "misalign_st");
    ld('h004, 3'b000, "misalign_wr", 32'h5A5A5A5A);
    st('h00C, 32'h00000001, 3'b000, "aligned_after");
    ld('h00C, 3'b000, "sticky", 32'h00000001);
    step(1'b0, 1'b0, 0, '0, 3'b000, 3'b000, 1'b0, 1'b0, "err_reset");
    ld('h004, 3'b000, "cleared_w1", 32'h0);

    step(1'b0, 1'b1, 'h014, 32'h11111111, 3'b000, 3'b000, 1'b0, 1'b0, "rst_mid_store");
    ld('h014, 3'b000, "rst_wins", 32'h0);

    for (int c = 0; c < 800; c++) begin
      we   = 1'($urandom_range(0, 1));
      lw   = 3'($urandom_range(0, 7));
      sw   = 3'($urandom_range(0, 7));
      wIdx = $urandom_range(0, 7);
      n    = we ? sizeBytes(sw[1:0]) : sizeBytes(lw[1:0]);
      lane = ($urandom_range(0, 19) == 0) ? $urandom_range(0, 3)
                                          : ($urandom_range(0, 3) / n) * n;
      addr = 4*wIdx + lane;
      if ($urandom_range(0, 99) == 0)
        step(1'b0, we, addr, $urandom, lw, sw, 1'b0, 1'b0, "rand_reset");
      else
        step(1'b1, we, addr, $urandom, lw, sw, 1'($urandom_range(0, 3) == 0),
             1'($urandom_range(0, 2) == 0), "rand");
    end

    for (int i = 0; i < 20 && expQ.size() > 0; i++) @(negedge clk);
    if (expQ.size() > 0) begin
      checks++;
      failures++;
      $display("FAIL drain: got %0d pending expectations expected 0", expQ.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
